// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - shared command-path types, widths and helpers
//
// Purpose: loader FSM state encoding, default command/address/bus widths
// shared with the command memory and processor fetch path, and the
// words-per-command helper.
// Ports: none (package).
package cmd_pkg;

  localparam int CMD_W      = 128;
  localparam int CMD_ADDR_W = 8;
  localparam int HOST_BUS_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Host words needed to fill one command (ceiling division).
  function automatic int words_per_cmd(input int cmd_width, input int bus_width);
    return (cmd_width + bus_width - 1) / bus_width;
  endfunction

endpackage

// File: rtl/cmd_word_packer.sv
// rtl/cmd_word_packer.sv - packs host stream words into one command
//
// Purpose: word index counter plus slice-insert register. The first word of
// a command lands in the LSBs; bits of the final word beyond CMD_WIDTH are
// dropped.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   clear         restart at word 0 (new load)
//   xfer          a host word is accepted this cycle
//   s_data        host word
//   cmd_complete  this transfer finishes a command
//   cmd_data      assembled command including the current word
module cmd_word_packer
  import cmd_pkg::*;
#(
  parameter int CMD_WIDTH = CMD_W,
  parameter int BUS_WIDTH = HOST_BUS_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 xfer,
  input  logic [BUS_WIDTH-1:0] s_data,
  output logic                 cmd_complete,
  output logic [CMD_WIDTH-1:0] cmd_data
);

  localparam int WPC   = words_per_cmd(CMD_WIDTH, BUS_WIDTH);
  localparam int IDX_W = (WPC > 1) ? $clog2(WPC) : 1;
  localparam int BUF_W = WPC * BUS_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPC - 1);

  logic [IDX_W-1:0] word_idx;
  logic [BUF_W-1:0] buf_q;
  logic [BUF_W-1:0] buf_next;

  // Current word merged in combinationally so the top can register the
  // complete command on the same edge that accepts the final word.
  always_comb begin
    buf_next = buf_q;
    buf_next[int'(word_idx) * BUS_WIDTH +: BUS_WIDTH] = s_data;
  end

  assign cmd_complete = xfer && (word_idx == LAST_IDX);
  assign cmd_data     = buf_next[CMD_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      word_idx <= '0;
      buf_q    <= '0;
    end else if (clear) begin
      word_idx <= '0;
    end else if (xfer) begin
      buf_q    <= buf_next;
      word_idx <= (word_idx == LAST_IDX) ? '0 : word_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/cmd_loader.sv
// rtl/cmd_loader.sv - host stream to command memory write-side loader
//
// Purpose: accepts a ready/valid stream of host words, packs them into
// commands and writes them to consecutive command memory addresses starting
// at base_addr, num_cmds commands per load.
// Optional: CMD_LOADER_CHECKSUM_EN adds output checksum, the running XOR of
// every command written in the current load.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   start, base_addr, num_cmds   load request (accepted only in IDLE)
//   s_data, s_valid, s_ready     host word stream
//   write_enable, write_address,
//   cmd_out                      registered command memory write port
//   busy                         high in LOAD
//   done                         one-cycle completion pulse
//   checksum                     (CMD_LOADER_CHECKSUM_EN only)
module cmd_loader
  import cmd_pkg::*;
#(
  parameter int CMD_WIDTH  = CMD_W,
  parameter int ADDR_WIDTH = CMD_ADDR_W,
  parameter int BUS_WIDTH  = HOST_BUS_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_cmds,
  input  logic [BUS_WIDTH-1:0]  s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [CMD_WIDTH-1:0]  cmd_out,
  output logic                  busy,
  output logic                  done
`ifdef CMD_LOADER_CHECKSUM_EN
  ,
  output logic [CMD_WIDTH-1:0]  checksum
`endif
);

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  start_ok;
  logic                  xfer;
  logic                  cmd_complete;
  logic [CMD_WIDTH-1:0]  cmd_data;

  assign start_ok = (state == ST_IDLE) && start;
  assign xfer     = s_valid && s_ready;

  cmd_word_packer #(
    .CMD_WIDTH (CMD_WIDTH),
    .BUS_WIDTH (BUS_WIDTH)
  ) u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear        (start_ok),
    .xfer         (xfer),
    .s_data       (s_data),
    .cmd_complete (cmd_complete),
    .cmd_data     (cmd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = (num_cmds != '0) ? ST_LOAD : ST_DONE;
      ST_LOAD: if (cmd_complete && (remaining == (ADDR_WIDTH+1)'(1))) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready = (state == ST_LOAD);
    busy    = (state == ST_LOAD);
    done    = (state == ST_DONE);
  end

  // Write port, pointer and command counter. Pointer wraps silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr           <= '0;
      remaining     <= '0;
      write_enable  <= 1'b0;
      write_address <= '0;
      cmd_out       <= '0;
    end else begin
      write_enable <= 1'b0;
      if (start_ok) begin
        ptr       <= base_addr;
        remaining <= num_cmds;
      end else if (cmd_complete) begin
        write_enable  <= 1'b1;
        write_address <= ptr;
        cmd_out       <= cmd_data;
        ptr           <= ptr + 1'b1;
        remaining     <= remaining - 1'b1;
      end
    end
  end

`ifdef CMD_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || start_ok) checksum <= '0;
    else if (cmd_complete) checksum <= checksum ^ cmd_data;
  end
`endif

endmodule

// File: tb/tb_cmd_loader.sv
// tb/tb_cmd_loader.sv - directed self-checking bench for cmd_loader
module tb_cmd_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   base_addr;
  logic [8:0]   num_cmds;
  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_ready;
  logic         write_enable;
  logic [7:0]   write_address;
  logic [127:0] cmd_out;
  logic         busy;
  logic         done;
`ifdef CMD_LOADER_CHECKSUM_EN
  logic [127:0] checksum;
`endif

  cmd_loader dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .num_cmds      (num_cmds),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .write_enable  (write_enable),
    .write_address (write_address),
    .cmd_out       (cmd_out),
    .busy          (busy),
    .done          (done)
`ifdef CMD_LOADER_CHECKSUM_EN
    ,
    .checksum      (checksum)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  logic [7:0]   wr_addr [16];
  logic [127:0] wr_data [16];
  int           wr_cyc  [16];
  int           acc_cyc [16];
  int wr_n = 0, acc_n = 0, done_n = 0, done_cyc = -1, rdy_n = 0;
  int start_cyc;

  always @(negedge clk) begin
    if (write_enable) begin
      if (wr_n < 16) begin
        wr_addr[wr_n] = write_address;
        wr_data[wr_n] = cmd_out;
        wr_cyc[wr_n]  = cyc;
      end
      wr_n++;
    end
    if (s_valid && s_ready) begin
      if (acc_n < 16) acc_cyc[acc_n] = cyc;
      acc_n++;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (s_ready) rdy_n++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_n = 0; acc_n = 0; done_n = 0; done_cyc = -1; rdy_n = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] n);
    start = 1'b1; base_addr = b; num_cmds = n;
    tick();
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    s_valid = 1'b1; s_data = w;
    tick();
    s_valid = 1'b0;
    if (gap) tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; num_cmds = '0;
    s_data = '0; s_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_s_ready", s_ready, 0);
    check("rst_write_enable", write_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_write_address", write_address, 0);
    check("rst_cmd_out", cmd_out, 0);

    // Basic two-command load, continuous stream.
    clear_logs();
    do_start(8'h10, 9'd2);
    check("t1_busy", busy, 1);
    check("t1_s_ready", s_ready, 1);
    for (int i = 1; i <= 8; i++) send_word(32'(i), 1'b0);
    repeat (4) tick();
    check("t1_wr_count", wr_n, 2);
    check("t1_addr0", wr_addr[0], 8'h10);
    check("t1_data0", wr_data[0], 128'h00000004_00000003_00000002_00000001);
    check("t1_addr1", wr_addr[1], 8'h11);
    check("t1_data1", wr_data[1], 128'h00000008_00000007_00000006_00000005);
    check("t1_done_count", done_n, 1);
    check("t1_done_with_last_write", done_cyc, wr_cyc[1]);
    check("t1_busy_after", busy, 0);

    // Zero-command load.
    clear_logs();
    do_start(8'h50, 9'd0);
    repeat (4) tick();
    check("t2_done_count", done_n, 1);
    check("t2_done_cycle", done_cyc, start_cyc);
    check("t2_no_writes", wr_n, 0);
    check("t2_no_ready", rdy_n, 0);

    // Address wrap.
    clear_logs();
    do_start(8'hFF, 9'd2);
    for (int i = 0; i < 8; i++) send_word(32'h11 + 32'(i), 1'b0);
    repeat (4) tick();
    check("t3_wr_count", wr_n, 2);
    check("t3_addr0", wr_addr[0], 8'hFF);
    check("t3_addr1", wr_addr[1], 8'h00);
    check("t3_data1", wr_data[1], 128'h00000018_00000017_00000016_00000015);
    check("t3_done_count", done_n, 1);

    // s_valid toggling; start during LOAD must be ignored.
    clear_logs();
    do_start(8'h20, 9'd2);
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin
        start = 1'b1; base_addr = 8'h99; num_cmds = 9'd1;
      end
      send_word(32'(i), 1'b1);
      start = 1'b0;
    end
    repeat (4) tick();
    check("t4_wr_count", wr_n, 2);
    check("t4_addr0", wr_addr[0], 8'h20);
    check("t4_data0", wr_data[0], 128'h00000004_00000003_00000002_00000001);
    check("t4_addr1", wr_addr[1], 8'h21);
    check("t4_data1", wr_data[1], 128'h00000008_00000007_00000006_00000005);
    check("t4_accepts", acc_n, 8);
    check("t4_lat0", wr_cyc[0], acc_cyc[3] + 1);
    check("t4_lat1", wr_cyc[1], acc_cyc[7] + 1);
    check("t4_done_count", done_n, 1);

    // Reset after 6 of 8 words.
    clear_logs();
    do_start(8'h30, 9'd2);
    for (int i = 1; i <= 6; i++) send_word(32'h100 + 32'(i), 1'b0);
    reset = 1'b1; s_valid = 1'b0;
    tick();
    check("t5_ready_after_reset", s_ready, 0);
    check("t5_busy_after_reset", busy, 0);
    check("t5_we_after_reset", write_enable, 0);
    reset = 1'b0;
    repeat (4) tick();
    check("t5_wr_count", wr_n, 1);
    check("t5_addr0", wr_addr[0], 8'h30);
    check("t5_data0", wr_data[0], 128'h00000104_00000103_00000102_00000101);
    check("t5_no_done", done_n, 0);

    clear_logs();
    do_start(8'h40, 9'd1);
    for (int i = 9; i <= 12; i++) send_word(32'(i), 1'b0);
    repeat (4) tick();
    check("t6_wr_count", wr_n, 1);
    check("t6_addr0", wr_addr[0], 8'h40);
    check("t6_data0", wr_data[0], 128'h0000000c_0000000b_0000000a_00000009);
    check("t6_done_count", done_n, 1);

`ifdef CMD_LOADER_CHECKSUM_EN
    clear_logs();
    do_start(8'h60, 9'd2);
    check("t7_cs_cleared", checksum, 128'h0);
    for (int i = 0; i < 4; i++) send_word(32'hF0F0F0F0, 1'b0);
    for (int i = 0; i < 4; i++) send_word(32'h0F0F0F0F, 1'b0);
    repeat (4) tick();
    check("t7_cs_value", checksum, {128{1'b1}});
    do_start(8'h70, 9'd1);
    check("t7_cs_restart", checksum, 128'h0);
    for (int i = 0; i < 4; i++) send_word(32'hA5A5A5A5, 1'b0);
    repeat (4) tick();
    check("t7_cs_single", checksum, {4{32'hA5A5A5A5}});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
